match_gated_select: RTL and testbench
=====================================

MATCH_GATED_SELECT -- requirements
Module: match_gated_select

Interface
REQ-001 SHALL have parameter DW, default 4, data width in bits (1..32).
REQ-002 SHALL have parameter CW, default 6, control word width in bits (1..16).
REQ-003 SHALL have parameter DEFAULT, default 4'b0101 zero-extended to DW, the substitute output pattern.
REQ-004 SHALL have parameter HOLD, default 2, number of consecutive matching beats needed before data passes (1..15).
REQ-005 SHALL have parameter ERRW, default 8, error counter width.
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 Port list:
- clk  in  1  clock, rising edge.
- reset  in  1  async active-high reset.
- in_valid  in  1  input beat present this cycle.
- in_data  in  DW  candidate data.
- ctrl  in  CW  control word; a match is ctrl all ones.
- clr_err  in  1  synchronous clear of the error counter.
- out_valid  out  1  registered beat-valid.
- out_data  out  DW  registered selected data.
- out_match  out  1  1 = out_data is in_data, 0 = DEFAULT.
- err_count  out  ERRW  saturating count of mismatching valid beats.
- err_sat  out  1  err_count is at its maximum.
- state  out  2  debug view of the FSM (IDLE=0, ARM=1, PASS=2).

Function
REQ-008 SHALL evaluate match = &ctrl only on cycles with in_valid=1.
REQ-009 SHALL keep a run counter r, range 0..HOLD, counting consecutive matching valid beats and saturating at HOLD.
REQ-010 SHALL use FSM states IDLE (r=0), ARM (0<r<HOLD) and PASS (r=HOLD).
REQ-011 On a valid beat with a match: r_next = min(r+1, HOLD). The beat passes if r+1 >= HOLD. With HOLD=1 it goes IDLE->PASS directly.
REQ-012 On a valid beat without a match: r_next = 0, the state goes to IDLE from any state, and the beat does not pass.
REQ-013 On cycles with in_valid=0: r and the state hold, out_valid=0, and out_data/out_match hold their previous values.
REQ-014 Latency SHALL be exactly 1 cycle: out_valid, out_data and out_match are registered from the beat's cycle.
REQ-015 For a passing beat: out_data=in_data and out_match=1. For a non-passing beat: out_data=DEFAULT and out_match=0.
REQ-016 err_count SHALL increment by 1 on each valid mismatching beat and saturate at 2^ERRW-1 with no wrap.
REQ-017 err_sat SHALL equal (err_count == 2^ERRW-1), registered together with err_count.
REQ-018 clr_err SHALL set err_count to 0 on the next edge. It wins over a simultaneous mismatch, so the result is 0, not 1.
REQ-019 An in_valid beat arriving in the same cycle as a state change SHALL be judged on the pre-edge r, per REQ-011 and REQ-012.
REQ-020 Any X on ctrl during a valid beat SHALL be treated as a mismatch in simulation (assertion flags it).

Reset
REQ-021 Asserting reset SHALL immediately set:
- state=IDLE, r=0
- out_valid=0, out_data=DEFAULT, out_match=0
- err_count=0, err_sat=0
REQ-022 Reset asserted mid-run SHALL discard any partial ARM progress. The first valid beat after release is judged from r=0.
REQ-023 Release of reset SHALL take effect at the next rising edge, with no other internal synchronisation.

Structure
REQ-024 A shared package SHALL hold:
- the state enum (IDLE, ARM, PASS)
- the localparam DEFAULT_PATTERN = 4'b0101
- a function computing the run-counter width clog2(HOLD+1)
REQ-025 SHALL contain one sub-module, sat_counter (parameter width; ports inc, clr, count, at_max), used for err_count.
REQ-026 All outputs SHALL be driven from flops. No combinational path from inputs to outputs.

Verification (DW=4, CW=6, HOLD=2, ERRW=8 unless stated)
REQ-027 Reset then idle: reset pulse -> out_data=4'b0101, out_valid=0, err_count=0, state=IDLE.
REQ-028 Arming: beats (ctrl=6'h3F, data=4'hA), (6'h3F, 4'hB), (6'h3F, 4'hC) -> outputs:
- 0101/match 0
- B/match 1
- C/match 1
REQ-029 Break mid-run: in PASS, send (6'h3E, 4'h7) then (6'h3F, 4'h8) -> outputs 0101/0 then 0101/0, err_count=1, state ARM.
REQ-030 Gap tolerance: in ARM, drop in_valid for 5 cycles, then send (6'h3F, 4'h9) -> output 9/1 and out_valid low during the gap.
REQ-031 Saturation and clear: send 300 mismatching beats -> err_count=255, err_sat=1. Then clr_err together with a mismatch -> err_count=0.
REQ-032 HOLD=1 build: reset asserted mid-ARM is N/A there, so instead a first beat (6'h3F, 4'h3) -> output 3/1 with no arming beat.

Source files
------------

// File: rtl/match_gated_select_pkg.sv
// Shared types and constants for the match-gated selector: FSM encoding,
// the substitute data pattern and the run-counter sizing helper.
package match_gated_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_PASS = 2'd2
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b0101;

  // Bits needed to hold a run count in 0..hold.
  function automatic int run_width(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/match_gated_select_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max is registered
// alongside count so both change on the same edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_count;
  logic         r_at_max;
  logic [W-1:0] w_nxt;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    w_nxt = r_count;
    if (clr)                         w_nxt = '0;
    else if (inc && r_count != MAX)  w_nxt = r_count + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_at_max <= 1'b0;
    end else begin
      r_count  <= w_nxt;
      r_at_max <= (w_nxt == MAX);
    end
  end

  assign count  = r_count;
  assign at_max = r_at_max;

endmodule

// File: rtl/match_gated_select.sv
// Passes in_data only after HOLD consecutive valid beats with ctrl all ones;
// otherwise emits DEFAULT. Counts mismatching valid beats in a saturating counter.
module match_gated_select
  import match_gated_select_pkg::*;
#(
  parameter int            DW      = 4,
  parameter int            CW      = 6,
  parameter logic [DW-1:0] DEFAULT = DW'(DEFAULT_PATTERN),
  parameter int            HOLD    = 2,
  parameter int            ERRW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic [CW-1:0]   ctrl,
  input  logic            clr_err,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_match,
  output logic [ERRW-1:0] err_count,
  output logic            err_sat,
  output logic [1:0]      state
);

  localparam int              RW     = run_width(HOLD);
  localparam logic [RW-1:0]   HOLD_R = RW'(HOLD);
  localparam logic [RW:0]     HOLD_X = (RW+1)'(HOLD);

  state_t         r_state, w_state_nxt;
  logic [RW-1:0]  r_run, w_run_nxt;
  logic [RW:0]    w_inc;
  logic           w_match, w_pass, w_miss;
  logic           r_out_valid, r_out_match;
  logic [DW-1:0]  r_out_data;

  // An X on ctrl makes w_match X, which falls into the mismatch branch below.
  assign w_match = &ctrl;
  assign w_inc   = {1'b0, r_run} + (RW+1)'(1);

  always_comb begin
    w_run_nxt   = r_run;
    w_pass      = 1'b0;
    w_miss      = 1'b0;
    w_state_nxt = r_state;
    if (in_valid) begin
      if (w_match) begin
        w_pass    = (w_inc >= HOLD_X);
        w_run_nxt = w_pass ? HOLD_R : w_inc[RW-1:0];
      end else begin
        w_miss    = 1'b1;
        w_run_nxt = '0;
      end
    end
    if (w_run_nxt == '0)          w_state_nxt = ST_IDLE;
    else if (w_run_nxt == HOLD_R) w_state_nxt = ST_PASS;
    else                          w_state_nxt = ST_ARM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Output data/match only update on valid beats; idle cycles hold them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= DEFAULT;
      r_out_match <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_data  <= w_pass ? in_data : DEFAULT;
        r_out_match <= w_pass;
      end
    end
  end

  sat_counter #(.W(ERRW)) u_err (
    .clk    (clk),
    .rst    (reset),
    .inc    (w_miss),
    .clr    (clr_err),
    .count  (err_count),
    .at_max (err_sat)
  );

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_match = r_out_match;
  assign state     = r_state;

  a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
    in_valid |-> !$isunknown(ctrl));

endmodule

// File: tb/tb_match_gated_select.sv
// Table-driven bench with an output scoreboard for match_gated_select,
// plus a HOLD=1 instance for the direct-pass case.
module tb_match_gated_select;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, clr_err;
  logic [3:0] in_data;
  logic [5:0] ctrl;
  logic       out_valid, out_match, err_sat;
  logic [3:0] out_data;
  logic [7:0] err_count;
  logic [1:0] state;

  logic       v1, clr1, o1_valid, o1_match, o1_sat;
  logic [3:0] d1, o1_data;
  logic [5:0] c1;
  logic [7:0] o1_err;
  logic [1:0] st1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [5:0] c;
    logic [3:0] d;
    logic       clr;
    logic [3:0] ed;
    logic       em;
    logic [7:0] ee;
    logic [1:0] es;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic       m;
  } exp_t;

  vec_t tbl[$];
  exp_t expq[$];

  always #5 clk = ~clk;

  match_gated_select dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .ctrl(ctrl), .clr_err(clr_err), .out_valid(out_valid), .out_data(out_data),
    .out_match(out_match), .err_count(err_count), .err_sat(err_sat), .state(state)
  );

  match_gated_select #(.HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1),
    .ctrl(c1), .clr_err(clr1), .out_valid(o1_valid), .out_data(o1_data),
    .out_match(o1_match), .err_count(o1_err), .err_sat(o1_sat), .state(st1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid output pops the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("sb_data", out_data, e.d);
        chk("sb_match", out_match, e.m);
      end
    end
  end

  task automatic apply(input vec_t t);
    in_valid = t.v; ctrl = t.c; in_data = t.d; clr_err = t.clr;
    if (t.v) expq.push_back('{t.ed, t.em});
    @(negedge clk);
    chk("out_valid", out_valid, t.v);
    if (!t.v) begin
      chk("hold_data", out_data, t.ed);
      chk("hold_match", out_match, t.em);
    end
    chk("err_count", err_count, t.ee);
    chk("state", state, t.es);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; clr_err = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    reset = 1'b1; in_valid = 0; ctrl = 0; in_data = 0; clr_err = 0;
    v1 = 0; c1 = 0; d1 = 0; clr1 = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_data", out_data, 4'b0101);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_match", out_match, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_sat", err_sat, 0);
    chk("rst_state", state, 0);
    reset = 1'b0;
    @(negedge clk);

    //            v     ctrl   data  clr   exp_d exp_m err   state
    tbl.push_back('{1'b1, 6'h3F, 4'hA, 1'b0, 4'h5, 1'b0, 8'd0, 2'd1});
    tbl.push_back('{1'b1, 6'h3F, 4'hB, 1'b0, 4'hB, 1'b1, 8'd0, 2'd2});
    tbl.push_back('{1'b1, 6'h3F, 4'hC, 1'b0, 4'hC, 1'b1, 8'd0, 2'd2});
    tbl.push_back('{1'b1, 6'h3E, 4'h7, 1'b0, 4'h5, 1'b0, 8'd1, 2'd0});
    tbl.push_back('{1'b1, 6'h3F, 4'h8, 1'b0, 4'h5, 1'b0, 8'd1, 2'd1});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 6'h3F, 4'hF, 1'b0, 4'h5, 1'b0, 8'd1, 2'd1});
    tbl.push_back('{1'b1, 6'h3F, 4'h9, 1'b0, 4'h9, 1'b1, 8'd1, 2'd2});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 1'b0, 4'h9, 1'b1, 8'd1, 2'd2});
    tbl.push_back('{1'b1, 6'h00, 4'h1, 1'b0, 4'h5, 1'b0, 8'd2, 2'd0});
    tbl.push_back('{1'b1, 6'h3F, 4'h2, 1'b0, 4'h5, 1'b0, 8'd2, 2'd1});
    tbl.push_back('{1'b1, 6'h3F, 4'h3, 1'b0, 4'h3, 1'b1, 8'd2, 2'd2});
    tbl.push_back('{1'b1, 6'h00, 4'h4, 1'b1, 4'h5, 1'b0, 8'd0, 2'd0});
    tbl.push_back('{1'b1, 6'h3F, 4'h1, 1'b0, 4'h5, 1'b0, 8'd0, 2'd1});
    tbl.push_back('{1'b1, 6'h3F, 4'h2, 1'b0, 4'h2, 1'b1, 8'd0, 2'd2});
    tbl.push_back('{1'b1, 6'h3E, 4'h3, 1'b0, 4'h5, 1'b0, 8'd1, 2'd0});
    tbl.push_back('{1'b1, 6'h3F, 4'h4, 1'b0, 4'h5, 1'b0, 8'd1, 2'd1});
    foreach (tbl[i]) apply(tbl[i]);
    idle(1);
    chk("q_empty_pre_reset", expq.size(), 0);

    // Reset while armed: progress is discarded and outputs return to reset values.
    reset = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 4'b0101);
    @(negedge clk);
    reset = 1'b0;
    apply('{1'b1, 6'h3F, 4'hD, 1'b0, 4'h5, 1'b0, 8'd0, 2'd1});
    apply('{1'b1, 6'h3F, 4'hE, 1'b0, 4'hE, 1'b1, 8'd0, 2'd2});

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      t = '{1'b1, 6'h00, 4'h6, 1'b0, 4'h5, 1'b0, 8'd0, 2'd0};
      t.ee = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      apply(t);
      if (i == 253) chk("sat_254_flag", err_sat, 0);
      if (i == 254) chk("sat_255_flag", err_sat, 1);
    end
    chk("sat_final_flag", err_sat, 1);
    apply('{1'b1, 6'h01, 4'h6, 1'b1, 4'h5, 1'b0, 8'd0, 2'd0});
    chk("clr_sat_flag", err_sat, 0);
    idle(1);

    // HOLD=1 instance: first matching beat passes directly.
    v1 = 1'b1; c1 = 6'h3F; d1 = 4'h3;
    @(negedge clk);
    chk("h1_valid", o1_valid, 1);
    chk("h1_data", o1_data, 4'h3);
    chk("h1_match", o1_match, 1);
    chk("h1_state", st1, 2);
    c1 = 6'h3E; d1 = 4'h4;
    @(negedge clk);
    chk("h1_miss_data", o1_data, 4'h5);
    chk("h1_miss_match", o1_match, 0);
    chk("h1_miss_state", st1, 0);
    c1 = 6'h3F; d1 = 4'h6;
    @(negedge clk);
    chk("h1_again_data", o1_data, 4'h6);
    chk("h1_again_match", o1_match, 1);
    v1 = 1'b0;
    @(negedge clk);
    chk("h1_idle_valid", o1_valid, 0);

    idle(2);
    chk("q_empty_end", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
